// File: rtl/p405s_trc_pkg.sv
// Shared trace FIFO constants and helpers, used by the control stage and the storage array.
package p405s_trc_pkg;

  localparam int unsigned TRC_FIFO_DEPTH = 16;
  localparam int unsigned TRC_FIFO_AW    = 4;
  localparam int unsigned TRC_FIFO_HWM   = 12;

  // Accepted operation for one cycle, after full/empty/flush qualification.
  typedef enum logic [1:0] {
    TRC_OP_IDLE = 2'b00,
    TRC_OP_PUSH = 2'b01,
    TRC_OP_POP  = 2'b10,
    TRC_OP_BOTH = 2'b11
  } trc_op_e;

  // One-hot line select; bit n of the result selects array line n.
  function automatic logic [0:TRC_FIFO_DEPTH-1] trc_line_sel(
    input logic [TRC_FIFO_AW-1:0] ptr
  );
    logic [0:TRC_FIFO_DEPTH-1] sel;
    sel      = '0;
    sel[ptr] = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/p405s_trc_fifo_ptr.sv
// Wrapping trace FIFO pointer: advances by one per enabled cycle, sync clear has priority.
module p405s_trc_fifo_ptr
  import p405s_trc_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_adv,
  input  logic                   i_clr,
  output logic [TRC_FIFO_AW-1:0] o_ptr
);

  logic [TRC_FIFO_AW-1:0] r_ptr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_ptr <= '0;
    else if (i_clr)
      r_ptr <= '0;
    else if (i_adv)
      r_ptr <= r_ptr + TRC_FIFO_AW'(1);
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/p405s_trc_fifo_ctl.sv
// Trace FIFO control: write-enable decode, read address, occupancy and status for the 16-line array.
module p405s_trc_fifo_ctl
  import p405s_trc_pkg::*;
(
  input  logic        CB,
  input  logic        resetCore,
  input  logic        trcPush,
  input  logic        trcPop,
  input  logic        trcFlush,
  output logic [0:15] trcFifoE1,
  output logic [0:3]  fifoRdAddrL2,
  output logic        trcFifoValid,
  output logic        trcFifoFull,
  output logic        trcFifoHwm,
  output logic        trcFifoOvfl,
  output logic [0:4]  trcFifoCount
);

  logic [TRC_FIFO_AW:0]   r_count;
  logic                   r_ovfl;
  logic [TRC_FIFO_AW-1:0] w_wr_ptr;
  logic [TRC_FIFO_AW-1:0] w_rd_ptr;
  logic                   w_full;
  logic                   w_valid;
  logic                   w_push_ok;
  logic                   w_pop_ok;
  trc_op_e                w_op;

  assign w_full    = (r_count == (TRC_FIFO_AW+1)'(TRC_FIFO_DEPTH));
  assign w_valid   = (r_count != '0);
  // Full/valid come from the registered count, so a same-cycle pop never makes room for a push.
  assign w_push_ok = trcPush & ~w_full & ~trcFlush;
  assign w_pop_ok  = trcPop & w_valid & ~trcFlush;

  always_comb begin
    w_op = TRC_OP_IDLE;
    unique case ({w_pop_ok, w_push_ok})
      2'b01:   w_op = TRC_OP_PUSH;
      2'b10:   w_op = TRC_OP_POP;
      2'b11:   w_op = TRC_OP_BOTH;
      default: w_op = TRC_OP_IDLE;
    endcase
  end

  p405s_trc_fifo_ptr u_wr_ptr (
    .i_clk (CB),
    .i_rst (resetCore),
    .i_adv (w_push_ok),
    .i_clr (trcFlush),
    .o_ptr (w_wr_ptr)
  );

  p405s_trc_fifo_ptr u_rd_ptr (
    .i_clk (CB),
    .i_rst (resetCore),
    .i_adv (w_pop_ok),
    .i_clr (trcFlush),
    .o_ptr (w_rd_ptr)
  );

  always_ff @(posedge CB or posedge resetCore) begin
    if (resetCore) begin
      r_count <= '0;
      r_ovfl  <= 1'b0;
    end else if (trcFlush) begin
      r_count <= '0;
      r_ovfl  <= 1'b0;
    end else begin
      unique case (w_op)
        TRC_OP_PUSH: r_count <= r_count + (TRC_FIFO_AW+1)'(1);
        TRC_OP_POP:  r_count <= r_count - (TRC_FIFO_AW+1)'(1);
        default:     r_count <= r_count;
      endcase
      if (trcPush && w_full)
        r_ovfl <= 1'b1;
    end
  end

  // Reset gates the enables so an in-flight push is never captured by the array.
  always_comb begin
    trcFifoE1 = '0;
    if (!resetCore && w_push_ok)
      trcFifoE1 = trc_line_sel(w_wr_ptr);
  end

  assign fifoRdAddrL2 = w_rd_ptr;
  assign trcFifoValid = w_valid;
  assign trcFifoFull  = w_full;
  assign trcFifoHwm   = (r_count >= (TRC_FIFO_AW+1)'(TRC_FIFO_HWM));
  assign trcFifoOvfl  = r_ovfl;
  assign trcFifoCount = r_count;

endmodule

// File: tb/tb_p405s_trc_fifo_ctl.sv
// Directed bench for the trace FIFO control stage with hand-computed expectations.
module tb_p405s_trc_fifo_ctl;

  logic        CB;
  logic        resetCore;
  logic        trcPush;
  logic        trcPop;
  logic        trcFlush;
  logic [0:15] trcFifoE1;
  logic [0:3]  fifoRdAddrL2;
  logic        trcFifoValid;
  logic        trcFifoFull;
  logic        trcFifoHwm;
  logic        trcFifoOvfl;
  logic [0:4]  trcFifoCount;

  int unsigned n_chk;
  int unsigned n_bad;
  int          wr;
  int          rd;
  logic [0:15] exp_e1;

  p405s_trc_fifo_ctl dut (
    .CB           (CB),
    .resetCore    (resetCore),
    .trcPush      (trcPush),
    .trcPop       (trcPop),
    .trcFlush     (trcFlush),
    .trcFifoE1    (trcFifoE1),
    .fifoRdAddrL2 (fifoRdAddrL2),
    .trcFifoValid (trcFifoValid),
    .trcFifoFull  (trcFifoFull),
    .trcFifoHwm   (trcFifoHwm),
    .trcFifoOvfl  (trcFifoOvfl),
    .trcFifoCount (trcFifoCount)
  );

  initial CB = 1'b0;
  always #5 CB = ~CB;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CB);
    #1;
  endtask

  task automatic drive(input logic push, input logic pop, input logic flush);
    trcPush  = push;
    trcPop   = pop;
    trcFlush = flush;
    #1;
  endtask

  function automatic logic [0:15] line(input int n);
    logic [0:15] v;
    v    = '0;
    v[n] = 1'b1;
    return v;
  endfunction

  task automatic chk_state(input string tag, input int cnt, input int addr, input logic ovfl);
    chk({tag, ".count"}, 32'(trcFifoCount), 32'(cnt));
    chk({tag, ".addr"},  32'(fifoRdAddrL2), 32'(addr));
    chk({tag, ".valid"}, 32'(trcFifoValid), 32'(cnt != 0));
    chk({tag, ".full"},  32'(trcFifoFull),  32'(cnt == 16));
    chk({tag, ".hwm"},   32'(trcFifoHwm),   32'(cnt >= 12));
    chk({tag, ".ovfl"},  32'(trcFifoOvfl),  32'(ovfl));
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    resetCore = 1'b1;
    trcPush = 1'b1; trcPop = 1'b0; trcFlush = 1'b0;
    #2;
    chk("rst.e1", 32'(trcFifoE1), 32'h0);
    step(); step();
    chk_state("rst", 0, 0, 1'b0);
    resetCore = 1'b0;

    // Fill: E1 walks lines 0..15
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      chk("fill.e1", 32'(trcFifoE1), 32'(line(i)));
      step();
      chk_state("fill", i + 1, 0, 1'b0);
    end

    // Push while full: dropped, overflow sticky
    drive(1'b1, 1'b0, 1'b0);
    chk("ovf.e1", 32'(trcFifoE1), 32'h0);
    step();
    chk_state("ovf", 16, 0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    step();
    chk_state("ovf.hold", 16, 0, 1'b1);

    // Push+pop while full: pop only, overflow set
    drive(1'b1, 1'b1, 1'b0);
    chk("fullpp.e1", 32'(trcFifoE1), 32'h0);
    step();
    chk_state("fullpp", 15, 1, 1'b1);

    // Flush+push: flush wins
    drive(1'b1, 1'b0, 1'b1);
    chk("flush.e1", 32'(trcFifoE1), 32'h0);
    step();
    chk_state("flush", 0, 0, 1'b0);

    // Push+pop while empty: push only
    drive(1'b1, 1'b1, 1'b0);
    chk("emptypp.e1", 32'(trcFifoE1), 32'(line(0)));
    step();
    chk_state("emptypp", 1, 0, 1'b0);
    for (int i = 1; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      step();
    end
    chk_state("five", 5, 0, 1'b0);

    // Push+pop at count 5
    drive(1'b1, 1'b1, 1'b0);
    chk("pp5.e1", 32'(trcFifoE1), 32'(line(5)));
    step();
    chk_state("pp5", 5, 1, 1'b0);

    // Drain to 3, then 20 push+pop cycles across the wrap
    drive(1'b0, 1'b1, 1'b0);
    step(); step();
    chk_state("three", 3, 3, 1'b0);
    wr = 6;
    rd = 3;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      exp_e1 = line(wr);
      chk("wrap.e1", 32'(trcFifoE1), 32'(exp_e1));
      step();
      wr = (wr + 1) % 16;
      rd = (rd + 1) % 16;
      chk_state("wrap", 3, rd, 1'b0);
    end

    // Drain, then pop on empty is ignored
    drive(1'b0, 1'b1, 1'b0);
    step(); step(); step();
    rd = (rd + 3) % 16;
    chk_state("drain", 0, rd, 1'b0);
    step();
    chk_state("popempty", 0, rd, 1'b0);

    // Reset mid-cycle with a push in flight
    drive(1'b1, 1'b0, 1'b0);
    step();
    chk_state("prerst", 1, rd, 1'b0);
    #2;
    resetCore = 1'b1;
    #1;
    chk("midrst.e1", 32'(trcFifoE1), 32'h0);
    chk_state("midrst", 0, 0, 1'b0);
    step();
    resetCore = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    chk_state("postrst", 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
